// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM states, mode constants and frame width.
package spi_pkg;

  // SPI mode 0: clock idles low and data is sampled on the rising edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  // Frame width in bits and the width of the bit counter that walks it.
  localparam int FRAME_W   = 8;
  localparam int BIT_CNT_W = $clog2(FRAME_W);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    SCK_HI    = 3'd2,
    SCK_LO    = 3'd3,
    CONT_WAIT = 3'd4,
    GUARD     = 3'd5
  } spi_state_t;

endpackage

// File: rtl/spi_sck_div.sv
// Half-period counter: counts down from CLK_DIV-1 and strobes tick on the last
// cycle of every timed phase, so each phase lasts exactly CLK_DIV clk cycles.
module spi_sck_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W  = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Reload on a new transfer or at each phase end; count down only while a timed phase runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= RELOAD;
    end else if (en) begin
      if (cnt_q == '0) begin
        cnt_q <= RELOAD;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit MSB-first frame per accepted start, optional
// SSEL hold between bytes (cont), and a guard interval after SSEL deasserts.
// Every pin-facing output comes straight from a flop.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont,
  input  logic [FRAME_W-1:0] tx_data,
  output logic [FRAME_W-1:0] rx_data,
  output logic               done,
  output logic               busy,
  output logic               SCK,
  output logic               MOSI,
  input  logic               MISO,
  output logic               SSEL
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);

  spi_state_t           state_q;
  spi_state_t           state_d;
  logic                 tick;
  logic                 start_ok;
  logic                 div_en;
  logic                 last_bit;
  logic [FRAME_W-1:0]   tx_sr_q;
  logic [FRAME_W-1:0]   rx_sr_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 cont_q;
  logic                 miso_s1_q;
  logic                 miso_s2_q;

  // A start is taken only when idle or parked between bytes, and never in the
  // done cycle, so a completion and a new request cannot act together.
  assign start_ok = start && !busy && !done &&
                    ((state_q == IDLE) || (state_q == CONT_WAIT));
  assign div_en   = (state_q == SETUP) || (state_q == SCK_HI) ||
                    (state_q == SCK_LO) || (state_q == GUARD);
  assign last_bit = (bit_cnt_q == LAST_BIT);

  spi_sck_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .en    (div_en),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous MISO pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= MISO;
      miso_s2_q <= miso_s1_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: timed phases advance on the divider tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, CONT_WAIT: if (start_ok) state_d = SETUP;
      SETUP:           if (tick) state_d = SCK_HI;
      SCK_HI:          if (tick) state_d = SCK_LO;
      SCK_LO: begin
        if (tick) begin
          if (!last_bit)   state_d = SCK_HI;
          else if (cont_q) state_d = CONT_WAIT;
          else             state_d = GUARD;
        end
      end
      GUARD:           if (tick) state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  // Shift registers, bit counter and registered pin/status outputs, updated at phase ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      cont_q    <= 1'b0;
      rx_data   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      SCK       <= CPOL;
      MOSI      <= 1'b0;
      SSEL      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE, CONT_WAIT: begin
          if (start_ok) begin
            MOSI      <= tx_data[FRAME_W-1];
            tx_sr_q   <= {tx_data[FRAME_W-2:0], 1'b0};
            cont_q    <= cont;
            bit_cnt_q <= '0;
            busy      <= 1'b1;
            SSEL      <= 1'b0;
            SCK       <= CPOL;
          end
        end
        SETUP: begin
          if (tick) SCK <= ~CPOL;
        end
        SCK_HI: begin
          // Sample on the last high cycle; present the next bit as SCK falls.
          if (tick) begin
            SCK     <= CPOL;
            rx_sr_q <= {rx_sr_q[FRAME_W-2:0], miso_s2_q};
            MOSI    <= tx_sr_q[FRAME_W-1];
            tx_sr_q <= {tx_sr_q[FRAME_W-2:0], 1'b0};
          end
        end
        SCK_LO: begin
          if (tick) begin
            if (!last_bit) begin
              bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
              SCK       <= ~CPOL;
            end else begin
              bit_cnt_q <= '0;
              rx_data   <= rx_sr_q;
              done      <= 1'b1;
              if (cont_q) begin
                busy <= 1'b0;
              end else begin
                SSEL <= 1'b1;
              end
            end
          end
        end
        GUARD: begin
          if (tick) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
